bitmanip_mulctl: RTL

BITMANIP_MULCTL -- requirements
Module: bitmanip_mulctl

---
 rtl/bitmanip_mulctl_pkg.sv | 33 +++
 rtl/bitmanip_mulctl_fixup.sv | 29 ++
 rtl/bitmanip_mulctl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bitmanip_mulctl_pkg.sv
// Shared types for the bit-manipulation multiply controller: op codes, FSM states,
// core latency and the operand absolute-value helper.
package bitmanip_mulctl_pkg;

    localparam int CORE_LATENCY = 4;

    typedef enum logic [2:0] {
        MULCTL_OP_CLMUL   = 3'd0,
        MULCTL_OP_CLMULH  = 3'd1,
        MULCTL_OP_CLMULR  = 3'd2,
        MULCTL_OP_MUL     = 3'd3,
        MULCTL_OP_MULH    = 3'd4,
        MULCTL_OP_MULHSU  = 3'd5,
        MULCTL_OP_MULHU   = 3'd6,
        MULCTL_OP_ILLEGAL = 3'd7
    } mulctl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } mulctl_state_e;

    // abs(0x80000000) wraps back to 0x80000000, which the unsigned core reads as 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic is_clmul(input mulctl_op_e op);
        return (op == MULCTL_OP_CLMUL) || (op == MULCTL_OP_CLMULH) || (op == MULCTL_OP_CLMULR);
    endfunction

endpackage

// File: rtl/bitmanip_mulctl_fixup.sv
// Result post-processing: optional two's-complement negate of the 64-bit product
// followed by the per-op 32-bit slice.
module bitmanip_mulctl_fixup
    import bitmanip_mulctl_pkg::*;
(
    input  mulctl_op_e  op,
    input  logic        neg,
    input  logic [63:0] prod,
    output logic [31:0] rd
);

    logic [63:0] prod_n;

    always_comb begin
        prod_n = neg ? (~prod + 64'd1) : prod;
        rd     = 32'd0;
        case (op)
            MULCTL_OP_CLMUL:  rd = prod[31:0];
            MULCTL_OP_CLMULH: rd = prod[63:32];
            MULCTL_OP_CLMULR: rd = prod[62:31];
            MULCTL_OP_MUL:    rd = prod[31:0];
            MULCTL_OP_MULH:   rd = prod_n[63:32];
            MULCTL_OP_MULHSU: rd = prod_n[63:32];
            MULCTL_OP_MULHU:  rd = prod[63:32];
            default:          rd = 32'd0;
        endcase
    end

endmodule

// File: rtl/bitmanip_mulctl.sv
// Multiply / carry-less multiply controller in front of a 4-cycle 32x32 core.
// Optional feature: define BITMANIP_MULCTL_ZEROBYPASS_EN to skip the core for zero operands.
module bitmanip_mulctl
    import bitmanip_mulctl_pkg::*;
#(
    parameter int DISABLE_CLMUL = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic        out_err,
    output logic        core_start,
    output logic        core_mul,
    output logic [31:0] core_rs1,
    output logic [31:0] core_rs2,
    input  logic [63:0] core_rd,
    input  logic        core_busy,
    input  logic        core_done
);

    mulctl_state_e state_q, state_d;
    mulctl_op_e    op_q, op_d;
    logic          neg_q, neg_d;
    logic          kill_pending_q, kill_pending_d;
    logic [31:0]   out_rd_q, out_rd_d;
    logic          out_err_q, out_err_d;
    logic          released_q, released_d;

    mulctl_op_e    req_op;
    logic          op_clmul;
    logic          op_illegal;
    logic          zero_bypass;
    logic          accept;
    logic [31:0]   pre_rs1, pre_rs2;
    logic          pre_neg;
    logic [31:0]   fix_rd;

    assign req_op     = mulctl_op_e'(in_op);
    assign op_clmul   = is_clmul(req_op);
    assign op_illegal = (req_op == MULCTL_OP_ILLEGAL) || ((DISABLE_CLMUL != 0) && op_clmul);

`ifdef BITMANIP_MULCTL_ZEROBYPASS_EN
    assign zero_bypass = (in_rs1 == 32'd0) || (in_rs2 == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    // Signed ops feed magnitudes to the unsigned core and remember the sign of the product.
    always_comb begin
        pre_rs1 = in_rs1;
        pre_rs2 = in_rs2;
        pre_neg = 1'b0;
        case (req_op)
            MULCTL_OP_MULH: begin
                pre_rs1 = abs32(in_rs1);
                pre_rs2 = abs32(in_rs2);
                pre_neg = in_rs1[31] ^ in_rs2[31];
            end
            MULCTL_OP_MULHSU: begin
                pre_rs1 = abs32(in_rs1);
                pre_neg = in_rs1[31];
            end
            default: ;
        endcase
    end

    // A killed op leaves the core running; hold off new work until it drains.
    assign in_ready   = released_q && (state_q == ST_IDLE) && !(kill_pending_q && core_busy);
    assign accept     = in_valid && in_ready;
    assign core_start = accept && !op_illegal && !zero_bypass;
    assign core_mul   = !op_clmul;
    assign core_rs1   = pre_rs1;
    assign core_rs2   = pre_rs2;

    bitmanip_mulctl_fixup u_fixup (
        .op   (op_q),
        .neg  (neg_q),
        .prod (core_rd),
        .rd   (fix_rd)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        neg_d          = neg_q;
        kill_pending_d = kill_pending_q;
        out_rd_d       = out_rd_q;
        out_err_d      = out_err_q;
        released_d     = 1'b1;

        if (kill_pending_q && (core_done || !core_busy)) begin
            kill_pending_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d           = req_op;
                    neg_d          = pre_neg;
                    kill_pending_d = 1'b0;
                    if (op_illegal) begin
                        state_d   = ST_HOLD;
                        out_err_d = 1'b1;
                        out_rd_d  = 32'd0;
                    end else if (zero_bypass) begin
                        state_d   = ST_HOLD;
                        out_err_d = 1'b0;
                        out_rd_d  = 32'd0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_d        = ST_IDLE;
                    kill_pending_d = core_busy && !core_done;
                end else if (core_done) begin
                    state_d   = ST_HOLD;
                    out_rd_d  = fix_rd;
                    out_err_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= MULCTL_OP_CLMUL;
            neg_q          <= 1'b0;
            kill_pending_q <= 1'b0;
            out_rd_q       <= 32'd0;
            out_err_q      <= 1'b0;
            released_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            neg_q          <= neg_d;
            kill_pending_q <= kill_pending_d;
            out_rd_q       <= out_rd_d;
            out_err_q      <= out_err_d;
            released_q     <= released_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_rd    = out_rd_q;
    assign out_err   = out_err_q;

endmodule
